// File: rtl/tiny_sched_pkg.sv
// Shared types and parameter defaults for the tiny stage scheduler.
package tiny_sched_pkg;

  localparam int unsigned TS_LEN_W       = 16;
  localparam int unsigned TS_TIMEOUT_CYC = 1024;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } sched_state_e;

endpackage

// File: rtl/tiny_sched_wdog.sv
// Progress watchdog: fires when TIMEOUT_CYC consecutive active cycles pass without progress.
module tiny_sched_wdog
  import tiny_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TS_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic progress,
  output logic fire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!active || progress) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Fire on the cycle the count would reach the limit so the FSM leaves in step with it.
  assign fire = active && !progress && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/tiny_stage_sched.sv
// Command sequencer for a chain of tiny BF16 blocks: arms the chain, streams cmd_len beats, waits for drain.
// Optional watchdog compiled in with TINY_SCHED_TIMEOUT_EN.
module tiny_stage_sched
  import tiny_sched_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS  = 4,
  parameter int unsigned LEN_W       = TS_LEN_W,
  parameter int unsigned TIMEOUT_CYC = TS_TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [NUM_BLOCKS-1:0] cmd_en_mask,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  src_empty,
  output logic                  src_rd_en,
  input  logic                  sink_tvalid,
  output logic                  stage_start,
  output logic [NUM_BLOCKS-1:0] block_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  sched_state_e          state_q, state_d;
  logic [LEN_W-1:0]      len_q, issued_q, rcv_q, issued_d, rcv_d;
  logic [NUM_BLOCKS-1:0] mask_q;
  logic                  accept, counting, rd_en, wd_fire, err_w;

  assign accept   = (state_q == S_IDLE) && cmd_valid;
  assign counting = (state_q == S_ARM) || (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign rd_en    = (state_q == S_STREAM) && !src_empty && (issued_q < len_q);
  assign issued_d = issued_q + LEN_W'(rd_en);
  assign rcv_d    = rcv_q + LEN_W'(counting && sink_tvalid && (rcv_q != len_q));

`ifdef TINY_SCHED_TIMEOUT_EN
  logic wd_active;
  logic err_q;

  assign wd_active = (state_q == S_STREAM) || (state_q == S_DRAIN);

  tiny_sched_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (wd_active),
    .progress (rd_en || sink_tvalid),
    .fire     (wd_fire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (wd_fire) begin
      err_q <= 1'b1;
    end
  end

  assign err_w = err_q;
`else
  logic unused_cfg;
  assign wd_fire    = 1'b0;
  assign err_w      = 1'b0;
  assign unused_cfg = (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      mask_q   <= '0;
      issued_q <= '0;
      rcv_q    <= '0;
    end else if (accept) begin
      len_q    <= cmd_len;
      mask_q   <= cmd_en_mask;
      issued_q <= '0;
      rcv_q    <= '0;
    end else begin
      issued_q <= issued_d;
      rcv_q    <= rcv_d;
    end
  end

  // Transitions look at the post-increment counts so the last read / last beat retires the phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cmd_valid) state_d = (cmd_len == '0) ? S_DONE : S_ARM;
      S_ARM:    state_d = S_STREAM;
      S_STREAM: begin
        if (wd_fire)                    state_d = S_DONE;
        else if (issued_d == len_q)     state_d = S_DRAIN;
      end
      S_DRAIN:  if (wd_fire || (rcv_d == len_q)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    stage_start = counting;
    done        = (state_q == S_DONE);
    src_rd_en   = rd_en;
    block_en    = mask_q;
    err         = err_w;
  end

endmodule

// File: tb/tb_tiny_stage_sched.sv
// Scoreboard bench for tiny_stage_sched; the chain tail is a 6-deep delay of src_rd_en.
module tb_tiny_stage_sched;

  localparam int unsigned NB = 4;
  localparam int unsigned LW = 16;
  localparam int unsigned D  = 6;
`ifdef TINY_SCHED_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 1024;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [NB-1:0] cmd_en_mask = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          src_empty = 1'b0;
  logic          sink_tvalid;
  logic          cmd_ready, src_rd_en, stage_start, busy, done, err;
  logic [NB-1:0] block_en;

  logic [D-1:0]  tail_sr = '0;
  logic          sink_extra = 1'b0;
  logic          tail_mute = 1'b0;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_bad = 0;

  typedef struct {
    logic [NB-1:0] mask;
    int            reads;
    int            done_cyc;
    int            first_cyc;
    int            last_cyc;
    logic          err;
  } exp_t;

  exp_t sb[$];

  tiny_stage_sched #(
    .NUM_BLOCKS  (NB),
    .LEN_W       (LW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_en_mask (cmd_en_mask),
    .cmd_len     (cmd_len),
    .src_empty   (src_empty),
    .src_rd_en   (src_rd_en),
    .sink_tvalid (sink_tvalid),
    .stage_start (stage_start),
    .block_en    (block_en),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    tail_sr <= {tail_sr[D-2:0], src_rd_en};
  end

  assign sink_tvalid = (tail_sr[D-1] & ~tail_mute) | sink_extra;

  // Call at a negedge; returns at the negedge of the cycle after done.
  task automatic run_cmd(input logic [NB-1:0] mask, input int len, input int stall_after,
                         input int stall_len, input bit extra, input bit poke, input int done_off,
                         input int first_off, input int last_off, input logic exp_err);
    exp_t e, g;
    int t, reads, first_rd, last_rd, ss_cnt, busy_cnt, ready_bad, stall_left, waitc;
    bit got;
    reads = 0; first_rd = -1; last_rd = -1; ss_cnt = 0; busy_cnt = 0;
    ready_bad = 0; stall_left = stall_len; got = 1'b0; waitc = 0;
    while (cmd_ready !== 1'b1 && waitc < 64) begin
      @(negedge clk);
      waitc++;
    end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
      n_bad++;
      return;
    end
    cmd_valid = 1'b1; cmd_en_mask = mask; cmd_len = LW'(len); t = cyc;
    e.mask = mask; e.reads = len; e.done_cyc = t + done_off;
    e.first_cyc = (first_off < 0) ? -1 : t + first_off;
    e.last_cyc  = (last_off < 0) ? -1 : t + last_off;
    e.err = exp_err;
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_en_mask = '0; cmd_len = '0;
    n_vec++;
    if (err !== 1'b0) begin
      $display("FAIL err_clear_on_accept: got %b want 0", err);
      n_bad++;
    end
    for (int k = 0; k < 300 && !got; k++) begin
      src_empty = 1'b0;
      if (stall_left > 0 && reads >= stall_after) begin
        src_empty = 1'b1;
        stall_left--;
      end
      sink_extra  = extra && (cyc == t + 1 || cyc == t + 2);
      cmd_valid   = poke && (cyc == t + 3);
      cmd_en_mask = cmd_valid ? ~mask : '0;
      cmd_len     = cmd_valid ? 16'd9 : '0;
      #1;
      if (src_rd_en === 1'b1) begin
        reads++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (stage_start === 1'b1) ss_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (cmd_ready === busy) ready_bad++;
      if (done === 1'b1) begin
        got = 1'b1;
        n_vec++;
        if (sb.size() == 0) begin
          $display("FAIL sb_underflow: got done with empty scoreboard want none");
          n_bad++;
        end else begin
          g = sb.pop_front();
          n_vec++;
          if (cyc !== g.done_cyc) begin
            $display("FAIL done_cycle: got T+%0d want T+%0d", cyc - t, g.done_cyc - t); n_bad++;
          end
          n_vec++;
          if (block_en !== g.mask) begin
            $display("FAIL block_en: got %b want %b", block_en, g.mask); n_bad++;
          end
          n_vec++;
          if (reads !== g.reads) begin
            $display("FAIL read_count: got %0d want %0d", reads, g.reads); n_bad++;
          end
          n_vec++;
          if (err !== g.err) begin
            $display("FAIL err_at_done: got %b want %b", err, g.err); n_bad++;
          end
          n_vec++;
          if (stage_start !== 1'b0) begin
            $display("FAIL stage_in_done: got %b want 0", stage_start); n_bad++;
          end
          n_vec++;
          if (ss_cnt !== ((g.reads == 0) ? 0 : g.done_cyc - t - 1)) begin
            $display("FAIL stage_cycles: got %0d want %0d", ss_cnt,
                     (g.reads == 0) ? 0 : g.done_cyc - t - 1); n_bad++;
          end
          n_vec++;
          if (busy_cnt !== g.done_cyc - t) begin
            $display("FAIL busy_cycles: got %0d want %0d", busy_cnt, g.done_cyc - t); n_bad++;
          end
          n_vec++;
          if (ready_bad !== 0) begin
            $display("FAIL ready_vs_busy: got %0d bad cycles want 0", ready_bad); n_bad++;
          end
          if (g.first_cyc >= 0) begin
            n_vec++;
            if (first_rd !== g.first_cyc) begin
              $display("FAIL first_read: got T+%0d want T+%0d", first_rd - t, g.first_cyc - t); n_bad++;
            end
          end
          if (g.last_cyc >= 0) begin
            n_vec++;
            if (last_rd !== g.last_cyc) begin
              $display("FAIL last_read: got T+%0d want T+%0d", last_rd - t, g.last_cyc - t); n_bad++;
            end
          end
        end
      end else begin
        @(negedge clk);
      end
    end
    src_empty = 1'b0; sink_extra = 1'b0; cmd_valid = 1'b0; cmd_en_mask = '0; cmd_len = '0;
    if (!got) begin
      n_bad++;
      $display("FAIL done_timeout: got no done want done at T+%0d", done_off);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      $display("FAIL after_done: got ready=%b done=%b want ready=1 done=0", cmd_ready, done);
      n_bad++;
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    @(negedge clk); #1;
    n_vec++;
    if ({src_rd_en, stage_start, busy, done, err, block_en} !== '0) begin
      $display("FAIL reset_outputs: got %b want 0", {src_rd_en, stage_start, busy, done, err, block_en});
      n_bad++;
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1 || {src_rd_en, stage_start, busy, done, err, block_en} !== '0) begin
      $display("FAIL post_reset: got ready=%b others=%b want ready=1 others=0", cmd_ready,
               {src_rd_en, stage_start, busy, done, err, block_en});
      n_bad++;
    end
  endtask

  task automatic test_basic();
    run_cmd(4'b0101, 4, 999, 0, 1'b0, 1'b0, 12, 2, 5, 1'b0);
  endtask

  task automatic test_len_zero();
    run_cmd(4'b1010, 0, 999, 0, 1'b0, 1'b0, 1, -1, -1, 1'b0);
  endtask

  task automatic test_stall();
    run_cmd(4'b1111, 5, 2, 3, 1'b0, 1'b0, 16, 2, 9, 1'b0);
  endtask

  task automatic test_saturate();
    int extra_done;
    extra_done = 0;
    run_cmd(4'b0011, 5, 999, 0, 1'b1, 1'b0, 11, 2, 6, 1'b0);
    for (int k = 0; k < 8; k++) begin
      #1;
      if (done === 1'b1) extra_done++;
      @(negedge clk);
    end
    n_vec++;
    if (extra_done !== 0) begin
      $display("FAIL single_done: got %0d extra done pulses want 0", extra_done);
      n_bad++;
    end
  endtask

  task automatic test_busy_cmd();
    run_cmd(4'b0110, 3, 999, 0, 1'b0, 1'b1, 11, 2, 4, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_cmd(4'b1000, 2, 999, 0, 1'b0, 1'b0, 10, 2, 3, 1'b0);
    run_cmd(4'b0001, 1, 999, 0, 1'b0, 1'b0, 9, 2, 2, 1'b0);
  endtask

  task automatic test_reset_mid();
    int reads, ndone;
    reads = 0; ndone = 0;
    cmd_valid = 1'b1; cmd_en_mask = 4'b1001; cmd_len = 16'd8;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_en_mask = '0; cmd_len = '0;
    for (int k = 0; k < 20 && reads < 3; k++) begin
      #1;
      if (src_rd_en === 1'b1) reads++;
      if (reads < 3) @(negedge clk);
    end
    n_vec++;
    if (reads !== 3) begin
      $display("FAIL mid_reads: got %0d want 3", reads); n_bad++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({src_rd_en, stage_start, busy, done, err, block_en} !== '0) begin
      $display("FAIL mid_reset_outputs: got %b want 0", {src_rd_en, stage_start, busy, done, err, block_en});
      n_bad++;
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || block_en !== '0) begin
      $display("FAIL mid_release: got ready=%b busy=%b block_en=%b want 1 0 0000", cmd_ready, busy, block_en);
      n_bad++;
    end
    for (int k = 0; k < 10; k++) begin
      #1;
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    n_vec++;
    if (ndone !== 0) begin
      $display("FAIL mid_no_done: got %0d done pulses want 0", ndone); n_bad++;
    end
  endtask

`ifdef TINY_SCHED_TIMEOUT_EN
  task automatic test_watchdog();
    tail_mute = 1'b1;
    run_cmd(4'b1100, 4, 999, 0, 1'b0, 1'b0, 22, 2, 5, 1'b1);
    tail_mute = 1'b0;
    n_vec++;
    if (err !== 1'b1) begin
      $display("FAIL err_sticky: got %b want 1", err); n_bad++;
    end
    run_cmd(4'b0010, 2, 999, 0, 1'b0, 1'b0, 10, 2, 3, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_stall();
    test_saturate();
    test_busy_cmd();
    test_back_to_back();
    test_reset_mid();
`ifdef TINY_SCHED_TIMEOUT_EN
    test_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1, "simulation time limit");
  end

endmodule
